nbout_packer: RTL and testbench
===============================

Name: nbout_packer

Overview:
Packs reduced-precision output neuron values (n bits each, 1..16) contiguously into BIT_WIDTH-bit words for writeback to NBout memory. It is the write-side counterpart of the input unpacker: words it produces, when fed to the unpacker with the same n, reproduce the original low-n-bit values. It sits between the output pipeline (one value per cycle) and the memory write port, with valid/ready handshakes on both sides and an explicit flush that closes a group.

Parameters:
BIT_WIDTH, 16, full-precision value width and packed word width
PTR_BITS, 5, log2(2*BIT_WIDTH); width of the internal fill pointer

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i_valid  input  1  value present on i_data
i_data  input  BIT_WIDTH  value; only bits [n-1:0] are packed, upper bits ignored
i_n  input  PTR_BITS-1  precision n; 0 encodes BIT_WIDTH
i_flush  input  1  close group; qualified by o_ready, may be asserted with or without i_valid
o_ready  output  1  value/flush accepted this cycle when high
o_valid  output  1  o_data holds a packed word
o_data  output  BIT_WIDTH  packed word, LSB-first fill
o_last  output  1  word is the final word of a flushed group
i_ready  input  1  downstream accepts o_data this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset: acc=0, cnt=0, state=RUN, o_valid=0, o_data=0, o_last=0. Reset mid-group discards partial bits and any pending word.
- Storage: acc is the 2*BIT_WIDTH accumulator. cnt (0..BIT_WIDTH-1 between cycles) is the number of valid bits in acc.
- Output register: single entry. A held word is consumed when o_valid && i_ready.
- o_ready = (state==RUN) && (!o_valid || i_ready). This is combinational from registered state and i_ready.
- Accept (i_valid && o_ready): acc[cnt +: n] <= i_data[n-1:0], then cnt += n.
  - If the new cnt >= BIT_WIDTH: o_data <= acc[BIT_WIDTH-1:0] (including the new bits), o_valid=1 next cycle, acc shifts right by BIT_WIDTH, cnt -= BIT_WIDTH.
  - Latency: a word completed by an accepted value is visible one cycle after acceptance.
  - Throughput: one value per cycle while downstream is ready, including n=16.
- Flush (i_flush && o_ready), applied after any same-cycle value insert:
  - No complete word and cnt>0: emit acc zero-padded above cnt, o_last=1, cnt=0.
  - Complete word and residual cnt>0: emit the complete word with o_last=0, then go to DRAIN.
  - Complete word and residual 0: emit it with o_last=1.
  - Nothing buffered (cnt==0, no word): no output and no state change.
- DRAIN state:
  - o_ready=0.
  - When the output register frees (!o_valid || i_ready), load the zero-padded residual with o_last=1, set cnt=0 and acc=0, and return to RUN.
- States: RUN and DRAIN only.
- While o_valid && !i_ready, o_data and o_last hold stable.
- i_n may change per value. Precision is not latched per group.
- i_flush and i_valid are ignored when o_ready=0. Upstream must hold them.
- Bits of acc above cnt are always zero; zero padding relies on this invariant.

Decomposition:
- Shared package holds: BIT_WIDTH, PTR_BITS, the i_n==0 to BIT_WIDTH decode function, and the state encoding (RUN, DRAIN).
- Natural sub-module: nbout_word_reg, the one-entry output register with valid/ready, o_data and o_last. The packer datapath and FSM remain in nbout_packer.

Test Plan:
1. n=4 (i_n=4), values 0x1, 0x2, 0x3, 0x4 back-to-back with i_ready=1 -> one word 0x4321, o_last=0, visible the cycle after the 4th accept.
2. n=12: 0xABC then 0x123, then flush alone -> words 0x3ABC (o_last=0) then 0x0012 (o_last=1); cnt returns to 0.
3. n=16 (i_n=0): 0xBEEF, 0x1234, 0xCAFE on consecutive cycles, i_ready=1 -> same three words on consecutive cycles; o_ready stays 1.
4. n=4: values 1, 2, 3, then i_flush together with an n=8 value 0xA5 -> 0x5321 (o_last=0), DRAIN with o_ready=0, then 0x000A (o_last=1).
5. Backpressure: i_ready=0 while a word is held -> o_data and o_last stable, o_ready=0, no values lost; release -> resumes in order.
6. Reset asserted asynchronously mid-group (cnt=8, o_valid=1) -> o_valid, o_data, o_last clear immediately; after release, 0x1, 0x2, 0x3, 0x4 at n=4 yield 0x4321.

Source files
------------

// File: rtl/nbout_packer_pkg.sv
// rtl/nbout_packer_pkg.sv - shared widths, precision decode and FSM encoding for the NBout packer
package nbout_packer_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int PTR_BITS  = 5;
  localparam int ACC_W     = 2 * BIT_WIDTH;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // i_n == 0 stands for full precision
  function automatic logic [PTR_BITS-1:0] decode_n(input logic [PTR_BITS-2:0] n);
    return (n == '0) ? PTR_BITS'(BIT_WIDTH) : {1'b0, n};
  endfunction
endpackage

// File: rtl/nbout_packer_if.sv
// rtl/nbout_packer_if.sv - value-in / packed-word-out handshake bundle
interface nbout_packer_if;
  import nbout_packer_pkg::*;

  logic                  i_valid;
  logic [BIT_WIDTH-1:0]  i_data;
  logic [PTR_BITS-2:0]   i_n;
  logic                  i_flush;
  logic                  o_ready;
  logic                  o_valid;
  logic [BIT_WIDTH-1:0]  o_data;
  logic                  o_last;
  logic                  i_ready;

  modport master (
    output i_valid, i_data, i_n, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  i_valid, i_data, i_n, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/nbout_word_reg.sv
// rtl/nbout_word_reg.sv - one-entry output word register with valid/ready
module nbout_word_reg
  import nbout_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_data,
  input  logic                 load_last,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last
);
  logic                 valid_d, valid_q;
  logic [BIT_WIDTH-1:0] data_d, data_q;
  logic                 last_d, last_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
endmodule

// File: rtl/nbout_packer.sv
// rtl/nbout_packer.sv - packs n-bit values LSB-first into BIT_WIDTH-bit words with group flush
module nbout_packer
  import nbout_packer_pkg::*;
(
  input logic           clk,
  input logic           rst,
  nbout_packer_if.slave bus
);
  state_t               state_d, state_q;
  logic [ACC_W-1:0]     acc_d, acc_q;
  logic [PTR_BITS-1:0]  cnt_d, cnt_q;

  logic [PTR_BITS-1:0]  n_dec;
  logic [ACC_W-1:0]     ins;
  logic [ACC_W-1:0]     acc_ins;
  logic [PTR_BITS-1:0]  cnt_ins;
  logic                 wr_free;
  logic                 ready;
  logic                 load;
  logic [BIT_WIDTH-1:0] load_data;
  logic                 load_last;

  assign n_dec   = decode_n(bus.i_n);
  assign wr_free = !bus.o_valid || bus.i_ready;
  assign ready   = (state_q == ST_RUN) && wr_free;
  assign bus.o_ready = ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;

    // Relies on acc bits above cnt being zero, so OR is an insert
    ins     = {{BIT_WIDTH{1'b0}}, bus.i_data} & ~({ACC_W{1'b1}} << n_dec);
    ins     = ins << cnt_q;
    acc_ins = acc_q;
    cnt_ins = cnt_q;
    if (bus.i_valid && ready) begin
      acc_ins = acc_q | ins;
      cnt_ins = cnt_q + n_dec;
    end

    case (state_q)
      ST_RUN: begin
        if (ready) begin
          if (cnt_ins >= PTR_BITS'(BIT_WIDTH)) begin
            load      = 1'b1;
            load_data = acc_ins[BIT_WIDTH-1:0];
            acc_d     = acc_ins >> BIT_WIDTH;
            cnt_d     = cnt_ins - PTR_BITS'(BIT_WIDTH);
            if (bus.i_flush) begin
              if (cnt_d != '0) state_d = ST_DRAIN;
              else             load_last = 1'b1;
            end
          end else begin
            acc_d = acc_ins;
            cnt_d = cnt_ins;
            if (bus.i_flush && cnt_ins != '0) begin
              load      = 1'b1;
              load_data = acc_ins[BIT_WIDTH-1:0];
              load_last = 1'b1;
              acc_d     = '0;
              cnt_d     = '0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (wr_free) begin
          load      = 1'b1;
          load_data = acc_q[BIT_WIDTH-1:0];
          load_last = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  nbout_word_reg u_word_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .i_ready   (bus.i_ready),
    .o_valid   (bus.o_valid),
    .o_data    (bus.o_data),
    .o_last    (bus.o_last)
  );
endmodule

// File: tb/tb_nbout_packer.sv
// tb/tb_nbout_packer.sv - scoreboard bench for nbout_packer
module tb_nbout_packer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nbout_packer_if bus ();

  nbout_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  logic [16:0] exp_e;
  bit          mb[$];

  // Bit-serial reference: values become a LSB-first bit stream cut into 16-bit words
  task automatic model_push(input logic [15:0] v, input logic [3:0] n, input bit fl, input bit val);
    int nn;
    logic [15:0] w;
    nn = (n == 0) ? 16 : int'(n);
    if (val) for (int i = 0; i < nn; i++) mb.push_back(v[i]);
    if (mb.size() >= 16) begin
      for (int i = 0; i < 16; i++) w[i] = mb.pop_front();
      exp_q.push_back({(fl && mb.size() == 0), w});
    end
    if (fl && mb.size() > 0) begin
      w = '0;
      for (int i = 0; mb.size() > 0; i++) w[i] = mb.pop_front();
      exp_q.push_back({1'b1, w});
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h last=%b", bus.o_data, bus.o_last);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.o_last, bus.o_data} !== exp_e) begin
          failures++;
          $display("FAIL word got=%h last=%b exp=%h last=%b", bus.o_data, bus.o_last, exp_e[15:0], exp_e[16]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [3:0] n, input bit fl, input bit val, output int stalls);
    stalls = 0;
    bus.i_valid = val;
    bus.i_data  = v;
    bus.i_n     = n;
    bus.i_flush = fl;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      stalls++;
      if (stalls > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout stalls=%0d", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    model_push(v, n, fl, val);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_n     = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    #12;
    checks++;
    if ({bus.o_valid, bus.o_last, bus.o_data} !== 18'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%h exp=0", bus.o_valid, bus.o_last, bus.o_data);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", bus.o_ready);
    end
  endtask

  task automatic test_n4();
    int s;
    for (int i = 1; i <= 4; i++) send(16'(i), 4'd4, 1'b0, 1'b1, s);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h4321 || bus.o_last !== 1'b0) begin
      failures++;
      $display("FAIL n4_latency got v=%b d=%h l=%b exp v=1 d=4321 l=0", bus.o_valid, bus.o_data, bus.o_last);
    end
    wait_drain();
  endtask

  task automatic test_n12_flush();
    int s;
    send(16'h0ABC, 4'd12, 1'b0, 1'b1, s);
    send(16'h0123, 4'd12, 1'b0, 1'b1, s);
    send(16'h0000, 4'd12, 1'b1, 1'b0, s);
    checks++;
    if (bus.o_data !== 16'h0012 || bus.o_last !== 1'b1) begin
      failures++;
      $display("FAIL n12_flush got d=%h l=%b exp d=0012 l=1", bus.o_data, bus.o_last);
    end
    // A bare flush with nothing buffered must produce nothing
    send(16'h0000, 4'd4, 1'b1, 1'b0, s);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int s;
    int total;
    total = 0;
    send(16'hBEEF, 4'd0, 1'b0, 1'b1, s); total += s;
    send(16'h1234, 4'd0, 1'b0, 1'b1, s); total += s;
    send(16'hCAFE, 4'd0, 1'b0, 1'b1, s); total += s;
    checks++;
    if (total != 0) begin
      failures++;
      $display("FAIL b2b_stalls got=%0d exp=0", total);
    end
    wait_drain();
  endtask

  task automatic test_flush_drain();
    int s;
    for (int i = 1; i <= 3; i++) send(16'(i), 4'd4, 1'b0, 1'b1, s);
    send(16'h00A5, 4'd8, 1'b1, 1'b1, s);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_data !== 16'h5321 || bus.o_last !== 1'b0) begin
      failures++;
      $display("FAIL drain_state got r=%b d=%h l=%b exp r=0 d=5321 l=0", bus.o_ready, bus.o_data, bus.o_last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_data !== 16'h000A || bus.o_last !== 1'b1 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_word got d=%h l=%b r=%b exp d=000a l=1 r=1", bus.o_data, bus.o_last, bus.o_ready);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int s;
    bus.i_ready = 1'b0;
    send(16'h1111, 4'd0, 1'b0, 1'b1, s);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h2222;
    bus.i_n     = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_data !== 16'h1111 || bus.o_last !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold got r=%b v=%b d=%h l=%b exp r=0 v=1 d=1111 l=0", bus.o_ready, bus.o_valid, bus.o_data, bus.o_last);
      end
    end
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    send(16'h2222, 4'd0, 1'b0, 1'b1, s);
    send(16'h3333, 4'd0, 1'b1, 1'b1, s);
    wait_drain();
  endtask

  task automatic test_async_reset();
    int s;
    bus.i_ready = 1'b0;
    send(16'h0ABC, 4'd12, 1'b0, 1'b1, s);
    send(16'h0123, 4'd12, 1'b0, 1'b1, s);
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid got=%b exp=1", bus.o_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_last !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%b d=%h l=%b exp 0", bus.o_valid, bus.o_data, bus.o_last);
    end
    exp_q.delete();
    mb.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'(i), 4'd4, 1'b0, 1'b1, s);
    checks++;
    if (bus.o_data !== 16'h4321 || bus.o_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_word got v=%b d=%h exp v=1 d=4321", bus.o_valid, bus.o_data);
    end
    wait_drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_n4();
    test_n12_flush();
    test_back_to_back();
    test_flush_drain();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
